// File: rtl/serv_rf_sp_ram_bridge_pkg.sv
// rtl/serv_rf_sp_ram_bridge_pkg.sv - macro control polarities and arbitration encoding
// Shared by the bridge top and its write buffer.
package serv_rf_sp_ram_bridge_pkg;

   // gf180 single-port macro controls are all active low.
   localparam logic CEN_ON   = 1'b0;
   localparam logic CEN_OFF  = 1'b1;
   localparam logic GWEN_WR  = 1'b0;
   localparam logic GWEN_RD  = 1'b1;
   // Per-bit write-mask values; replicate to the data width at the use site.
   localparam logic WEN_ALL  = 1'b0;
   localparam logic WEN_NONE = 1'b1;

   // What the single port does in the current cycle.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_READ   = 2'd1,
      ARB_DRAIN  = 2'd2,
      ARB_DIRECT = 2'd3
   } arb_e;

endpackage

// File: rtl/serv_rf_sp_ram_bridge_if.sv
// rtl/serv_rf_sp_ram_bridge_if.sv - dual-port style register-file RAM request interface
// Signals: waddr/wdata/wen write side, raddr/ren read side, rdata read data
// returned the cycle after ren. master = register-file RAM interface,
// slave = the bridge.
interface serv_rf_sp_ram_bridge_if #(
   parameter int width = 8,
   parameter int aw    = 8
);
   logic [aw-1:0]    waddr;
   logic [width-1:0] wdata;
   logic             wen;
   logic [aw-1:0]    raddr;
   logic             ren;
   logic [width-1:0] rdata;

   modport master (output waddr, wdata, wen, raddr, ren, input rdata);
   modport slave  (input waddr, wdata, wen, raddr, ren, output rdata);
endinterface

// File: rtl/serv_rf_wbuf.sv
// rtl/serv_rf_wbuf.sv - write buffer FIFO with youngest-match address lookup
// Ports: i_push/i_addr/i_data enqueue, i_pop dequeues the head shown on
// o_head_addr/o_head_data, o_full/o_empty status, i_cmp_addr looked up
// against all valid entries giving o_hit/o_hit_data (youngest match wins).
// The caller must not push when full without a same-cycle pop, nor pop empty.
module serv_rf_wbuf #(
   parameter int width = 8,
   parameter int aw    = 8,
   parameter int depth = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [aw-1:0]    i_addr,
   input  logic [width-1:0] i_data,
   input  logic             i_pop,
   output logic [aw-1:0]    o_head_addr,
   output logic [width-1:0] o_head_data,
   output logic             o_full,
   output logic             o_empty,
   input  logic [aw-1:0]    i_cmp_addr,
   output logic             o_hit,
   output logic [width-1:0] o_hit_data
);
   localparam int pw = $clog2(depth);

   logic [aw-1:0]    addr_q [depth];
   logic [aw-1:0]    addr_d [depth];
   logic [width-1:0] data_q [depth];
   logic [width-1:0] data_d [depth];
   // Extra MSB is the wrap bit that separates full from empty.
   logic [pw:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [pw:0]      count;
   logic [pw-1:0]    idx;

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (i_push) begin
         addr_d[wptr_q[pw-1:0]] = i_addr;
         data_d[wptr_q[pw-1:0]] = i_data;
         wptr_d = wptr_q + (pw+1)'(1);
      end
      if (i_pop) begin
         rptr_d = rptr_q + (pw+1)'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q <= '{default: '0};
         data_q <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   assign count       = wptr_q - rptr_q;
   assign o_empty     = (wptr_q == rptr_q);
   assign o_full      = (wptr_q[pw] != rptr_q[pw]) && (wptr_q[pw-1:0] == rptr_q[pw-1:0]);
   assign o_head_addr = addr_q[rptr_q[pw-1:0]];
   assign o_head_data = data_q[rptr_q[pw-1:0]];

   // Walk from oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      o_hit      = 1'b0;
      o_hit_data = '0;
      idx        = '0;
      for (int k = 0; k < depth; k++) begin
         idx = rptr_q[pw-1:0] + pw'(k);
         if (((pw+1)'(k) < count) && (addr_q[idx] == i_cmp_addr)) begin
            o_hit      = 1'b1;
            o_hit_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/serv_rf_sp_ram_bridge.sv
// rtl/serv_rf_sp_ram_bridge.sv - two-port register-file RAM requests onto a single-port gf180 macro
// Ports: i_clk, i_rst_n (async active low); bus = request interface (slave);
// o_sram_cen/o_sram_gwen/o_sram_wen/o_sram_a/o_sram_d macro controls (active
// low), i_sram_q macro read data; o_busy write buffer non-empty;
// o_overflow sticky dropped-write flag.
module serv_rf_sp_ram_bridge
   import serv_rf_sp_ram_bridge_pkg::*;
#(
   parameter int width = 8,
   parameter int aw    = 8,
   parameter int depth = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   serv_rf_sp_ram_bridge_if.slave  bus,
   output logic                    o_sram_cen,
   output logic                    o_sram_gwen,
   output logic [width-1:0]        o_sram_wen,
   output logic [aw-1:0]           o_sram_a,
   output logic [width-1:0]        o_sram_d,
   input  logic [width-1:0]        i_sram_q,
   output logic                    o_busy,
   output logic                    o_overflow
);
   arb_e             arb;
   logic             push_req, push, pop, drop;
   logic             buf_full, buf_empty, hit;
   logic [aw-1:0]    head_addr;
   logic [width-1:0] head_data, hit_data;
   logic             fwd_hit_q, fwd_hit_d;
   logic [width-1:0] fwd_data_q, fwd_data_d;
   logic             overflow_q, overflow_d;

   serv_rf_wbuf #(.width(width), .aw(aw), .depth(depth)) u_wbuf (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (push),
      .i_addr      (bus.waddr),
      .i_data      (bus.wdata),
      .i_pop       (pop),
      .o_head_addr (head_addr),
      .o_head_data (head_data),
      .o_full      (buf_full),
      .o_empty     (buf_empty),
      .i_cmp_addr  (bus.raddr),
      .o_hit       (hit),
      .o_hit_data  (hit_data)
   );

   // Reads always own the port; buffered writes drain before any direct
   // write so a new write never overtakes an older one. Held idle in reset.
   always_comb begin
      arb = ARB_IDLE;
      if (i_rst_n) begin
         if (bus.ren)        arb = ARB_READ;
         else if (!buf_empty) arb = ARB_DRAIN;
         else if (bus.wen)   arb = ARB_DIRECT;
      end
   end

   always_comb begin
      push_req = bus.wen && ((arb == ARB_READ) || (arb == ARB_DRAIN));
      pop      = (arb == ARB_DRAIN);
      // A pop in the same cycle frees a slot, so full only drops without one.
      push     = push_req && (!buf_full || pop);
      drop     = push_req && !push;
   end

   always_comb begin
      o_sram_cen  = CEN_OFF;
      o_sram_gwen = GWEN_RD;
      o_sram_wen  = {width{WEN_NONE}};
      o_sram_a    = '0;
      o_sram_d    = '0;
      case (arb)
         ARB_READ: begin
            o_sram_cen = CEN_ON;
            o_sram_a   = bus.raddr;
         end
         ARB_DRAIN: begin
            o_sram_cen  = CEN_ON;
            o_sram_gwen = GWEN_WR;
            o_sram_wen  = {width{WEN_ALL}};
            o_sram_a    = head_addr;
            o_sram_d    = head_data;
         end
         ARB_DIRECT: begin
            o_sram_cen  = CEN_ON;
            o_sram_gwen = GWEN_WR;
            o_sram_wen  = {width{WEN_ALL}};
            o_sram_a    = bus.waddr;
            o_sram_d    = bus.wdata;
         end
         default: ;
      endcase
   end

   // The lookup sees the buffer before this cycle's push, so a same-cycle
   // write to the read address is not forwarded and the old data returns.
   always_comb begin
      fwd_hit_d  = (arb == ARB_READ) && hit;
      fwd_data_d = hit_data;
      overflow_d = overflow_q | drop;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.rdata  = fwd_hit_q ? fwd_data_q : i_sram_q;
   assign o_busy     = !buf_empty;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_serv_rf_sp_ram_bridge.sv
// tb/tb_serv_rf_sp_ram_bridge.sv - bench for serv_rf_sp_ram_bridge against a two-port RAM reference
module tb_serv_rf_sp_ram_bridge;
   localparam int W = 8;
   localparam int AW = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serv_rf_sp_ram_bridge_if #(.width(W), .aw(AW)) bus ();

   logic          cen, gwen, busy, ovf;
   logic [W-1:0]  wenm, sd, sq;
   logic [AW-1:0] sa;

   serv_rf_sp_ram_bridge #(.width(W), .aw(AW), .depth(D)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus),
      .o_sram_cen  (cen),
      .o_sram_gwen (gwen),
      .o_sram_wen  (wenm),
      .o_sram_a    (sa),
      .o_sram_d    (sd),
      .i_sram_q    (sq),
      .o_busy      (busy),
      .o_overflow  (ovf)
   );

   // Behavioural single-port macro.
   logic [W-1:0] sram_mem [256];
   logic [W-1:0] model_q = '0;
   logic [W-1:0] rand_q = '0;
   logic         rand_mode = 1'b1;
   assign sq = rand_mode ? rand_q : model_q;
   always @(posedge clk) begin
      if (!cen) begin
         if (!gwen) sram_mem[sa] <= (sram_mem[sa] & wenm) | (sd & ~wenm);
         else       model_q <= sram_mem[sa];
      end
   end

   // Reference two-port memory and scoreboards.
   logic [W-1:0]    lmem [256];
   logic [AW+W-1:0] exp_wr[$], obs_wr[$];
   logic [W-1:0]    exp_rd[$], obs_rd[$];
   logic            rd_pending = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge clk) rd_pending <= rst_n && bus.ren;
   always @(negedge clk) begin
      if (rst_n && !cen && !gwen) obs_wr.push_back({sa, sd});
      if (rd_pending) obs_rd.push_back(bus.rdata);
   end

   task automatic apply(input logic ren, input logic [7:0] raddr, input logic wen,
                        input logic [7:0] waddr, input logic [7:0] wdata, input logic drop);
      if (ren) exp_rd.push_back(lmem[raddr]);
      if (wen && !drop) begin
         exp_wr.push_back({waddr, wdata});
         lmem[waddr] = wdata;
      end
      bus.ren = ren; bus.raddr = raddr; bus.wen = wen; bus.waddr = waddr; bus.wdata = wdata;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_ticks(input int n);
      repeat (n) begin apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0); tick(); end
   endtask

   task automatic test_reset();
      logic [AW+W-1:0] ew, ow;
      rst_n = 1'b0; rand_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ren = 1'($urandom_range(0, 1)); bus.wen = 1'($urandom_range(0, 1));
         bus.raddr = 8'($urandom); bus.waddr = 8'($urandom); bus.wdata = 8'($urandom);
         rand_q = 8'($urandom);
         @(negedge clk); #1;
         n_cmp++;
         if ({cen, gwen, wenm, busy, ovf} !== {1'b1, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_ctrl got %b exp %b", {cen, gwen, wenm, busy, ovf}, 12'b1111111111_00);
         end
         n_cmp++;
         if (bus.rdata !== rand_q) begin n_bad++; $display("FAIL reset_rdata got %h exp %h", bus.rdata, rand_q); end
      end
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      tick();
      rand_mode = 1'b0; rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         apply(1'b0, 8'h0, 1'b1, 8'(i), 8'(i * 7 + 3), 1'b0); tick();
      end
      idle_ticks(2);
      @(negedge clk); #1;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL preload_wr got %h exp %h", ow, ew); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() != 0) begin
         n_bad++; $display("FAIL preload_wr_count got %0d left exp %0d left", obs_wr.size(), exp_wr.size());
         exp_wr.delete(); obs_wr.delete();
      end
      tick();
   endtask

   task automatic test_direct_write();
      logic [AW+W-1:0] ew, ow;
      apply(1'b0, 8'h0, 1'b1, 8'h12, 8'hA5, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if ({cen, gwen, wenm, sa, sd, busy} !== {1'b0, 1'b0, 8'h00, 8'h12, 8'hA5, 1'b0}) begin
         n_bad++; $display("FAIL direct_port got %h exp %h", {cen, gwen, wenm, sa, sd, busy}, {1'b0, 1'b0, 8'h00, 8'h12, 8'hA5, 1'b0});
      end
      tick(); idle_ticks(1);
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL direct_busy got %b exp 0", busy); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL direct_wr got %h exp %h", ow, ew); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() != 0) begin
         n_bad++; $display("FAIL direct_wr_count got %0d left exp %0d left", obs_wr.size(), exp_wr.size());
         exp_wr.delete(); obs_wr.delete();
      end
      tick();
   endtask

   task automatic test_collision();
      logic [AW+W-1:0] ew, ow;
      logic [W-1:0] er, orr;
      apply(1'b1, 8'h20, 1'b1, 8'h12, 8'h5A, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if ({cen, gwen, wenm, sa} !== {1'b0, 1'b1, 8'hFF, 8'h20}) begin
         n_bad++; $display("FAIL coll_read got %h exp %h", {cen, gwen, wenm, sa}, {1'b0, 1'b1, 8'hFF, 8'h20});
      end
      tick(); apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if ({cen, gwen, wenm, sa, sd, busy} !== {1'b0, 1'b0, 8'h00, 8'h12, 8'h5A, 1'b1}) begin
         n_bad++; $display("FAIL coll_drain got %h exp %h", {cen, gwen, wenm, sa, sd, busy}, {1'b0, 1'b0, 8'h00, 8'h12, 8'h5A, 1'b1});
      end
      tick();
      @(negedge clk); #1;
      n_cmp++;
      if ({busy, cen} !== 2'b01) begin n_bad++; $display("FAIL coll_empty got %b exp 01", {busy, cen}); end
      tick();
      @(negedge clk); #1;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL coll_wr got %h exp %h", ow, ew); end
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         er = exp_rd.pop_front(); orr = obs_rd.pop_front(); n_cmp++;
         if (orr !== er) begin n_bad++; $display("FAIL coll_rd got %h exp %h", orr, er); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() + exp_rd.size() + obs_rd.size() != 0) begin
         n_bad++; $display("FAIL coll_count got %0d/%0d left exp %0d/%0d left", obs_wr.size(), obs_rd.size(), exp_wr.size(), exp_rd.size());
         exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
      end
      tick();
   endtask

   task automatic test_forwarding();
      logic [AW+W-1:0] ew, ow;
      logic [W-1:0] er, orr;
      apply(1'b1, 8'h20, 1'b1, 8'h12, 8'h5A, 1'b0); tick();
      apply(1'b1, 8'h12, 1'b0, 8'h0, 8'h0, 1'b0); tick();
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if (bus.rdata !== 8'h5A) begin n_bad++; $display("FAIL fwd_single got %h exp 5a", bus.rdata); end
      tick(); idle_ticks(2);
      apply(1'b1, 8'h20, 1'b1, 8'h12, 8'h11, 1'b0); tick();
      apply(1'b1, 8'h21, 1'b1, 8'h12, 8'h22, 1'b0); tick();
      apply(1'b1, 8'h12, 1'b0, 8'h0, 8'h0, 1'b0); tick();
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if (bus.rdata !== 8'h22) begin n_bad++; $display("FAIL fwd_youngest got %h exp 22", bus.rdata); end
      tick(); idle_ticks(4);
      @(negedge clk); #1;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL fwd_wr got %h exp %h", ow, ew); end
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         er = exp_rd.pop_front(); orr = obs_rd.pop_front(); n_cmp++;
         if (orr !== er) begin n_bad++; $display("FAIL fwd_rd got %h exp %h", orr, er); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() + exp_rd.size() + obs_rd.size() != 0) begin
         n_bad++; $display("FAIL fwd_count got %0d/%0d left exp %0d/%0d left", obs_wr.size(), obs_rd.size(), exp_wr.size(), exp_rd.size());
         exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
      end
      tick();
   endtask

   task automatic test_same_cycle_raw();
      logic [AW+W-1:0] ew, ow;
      logic [W-1:0] er, orr;
      apply(1'b0, 8'h0, 1'b1, 8'h30, 8'h10, 1'b0); tick();
      apply(1'b1, 8'h30, 1'b1, 8'h30, 8'h77, 1'b0); tick();
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if (bus.rdata !== 8'h10) begin n_bad++; $display("FAIL raw_old got %h exp 10", bus.rdata); end
      tick(); idle_ticks(2);
      apply(1'b1, 8'h30, 1'b0, 8'h0, 8'h0, 1'b0); tick();
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if (bus.rdata !== 8'h77) begin n_bad++; $display("FAIL raw_new got %h exp 77", bus.rdata); end
      tick();
      @(negedge clk); #1;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL raw_wr got %h exp %h", ow, ew); end
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         er = exp_rd.pop_front(); orr = obs_rd.pop_front(); n_cmp++;
         if (orr !== er) begin n_bad++; $display("FAIL raw_rd got %h exp %h", orr, er); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() + exp_rd.size() + obs_rd.size() != 0) begin
         n_bad++; $display("FAIL raw_count got %0d/%0d left exp %0d/%0d left", obs_wr.size(), obs_rd.size(), exp_wr.size(), exp_rd.size());
         exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
      end
      tick();
   endtask

   task automatic test_overflow_reset();
      logic [AW+W-1:0] ew, ow;
      logic [W-1:0] er, orr;
      // Entries 2 and 3 are later discarded by reset, entry 4 is dropped as full.
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 8'(8'h20 + i), 1'b1, 8'(8'h50 + i), 8'(8'hC0 + i), i >= 2);
         @(negedge clk); #1;
         if (i == 4) begin
            n_cmp++;
            if ({ovf, busy} !== 2'b01) begin n_bad++; $display("FAIL ovf_before got %b exp 01", {ovf, busy}); end
         end
         tick();
      end
      apply(1'b0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk); #1;
      n_cmp++;
      if ({ovf, cen, gwen, sa} !== {1'b1, 1'b0, 1'b0, 8'h50}) begin
         n_bad++; $display("FAIL ovf_set got %h exp %h", {ovf, cen, gwen, sa}, {1'b1, 1'b0, 1'b0, 8'h50});
      end
      tick();
      @(negedge clk); #1;
      n_cmp++;
      if ({cen, gwen, sa} !== {1'b0, 1'b0, 8'h51}) begin
         n_bad++; $display("FAIL ovf_drain2 got %h exp %h", {cen, gwen, sa}, {1'b0, 1'b0, 8'h51});
      end
      tick();
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({cen, gwen, busy, ovf} !== 4'b1100) begin
         n_bad++; $display("FAIL ovf_in_reset got %b exp 1100", {cen, gwen, busy, ovf});
      end
      tick();
      rst_n = 1'b1;
      idle_ticks(6);
      @(negedge clk); #1;
      n_cmp++;
      if ({busy, ovf} !== 2'b00) begin n_bad++; $display("FAIL ovf_after_reset got %b exp 00", {busy, ovf}); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); n_cmp++;
         if (ow !== ew) begin n_bad++; $display("FAIL ovf_wr got %h exp %h", ow, ew); end
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         er = exp_rd.pop_front(); orr = obs_rd.pop_front(); n_cmp++;
         if (orr !== er) begin n_bad++; $display("FAIL ovf_rd got %h exp %h", orr, er); end
      end
      n_cmp++;
      if (exp_wr.size() + obs_wr.size() + exp_rd.size() + obs_rd.size() != 0) begin
         n_bad++; $display("FAIL ovf_count got %0d/%0d left exp %0d/%0d left", obs_wr.size(), obs_rd.size(), exp_wr.size(), exp_rd.size());
         exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.ren = 1'b0; bus.wen = 1'b0; bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
      #1;
      test_reset();
      test_direct_write();
      test_collision();
      test_forwarding();
      test_same_cycle_raw();
      test_overflow_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/serv_rf_sp_ram_bridge.md
Name: serv_rf_sp_ram_bridge

Overview:
- Sits directly downstream of the register-file RAM interface.
- Maps its dual-port style request stream (independent read and write strobes, 1-cycle registered read latency) onto a single-port gf180 SRAM macro. The macro has an active-low chip enable, an active-low global write enable and an active-low per-bit write mask.
- Reads always win the single port. Colliding writes are parked in a small write buffer and drained in idle cycles.
- Read-after-write hazards are resolved by forwarding from the buffer, so the upstream side sees plain two-port RAM semantics.

Parameters:
- width, 8, data width; must match the upstream RAM interface data width.
- aw, 8, RAM word address width; matches the upstream address width (5+6-3 for 4 CSRs at width 8).
- depth, 4, write-buffer entries; power of two, minimum 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_waddr  in  aw  write word address from the RAM interface.
- i_wdata  in  width  write data.
- i_wen  in  1  write strobe.
- i_raddr  in  aw  read word address.
- i_ren  in  1  read strobe.
- o_rdata  out  width  read data, valid the cycle after i_ren.
- o_sram_cen  out  1  macro chip enable, active low.
- o_sram_gwen  out  1  macro global write enable, active low.
- o_sram_wen  out  width  macro bit write mask, active low.
- o_sram_a  out  aw  macro address.
- o_sram_d  out  width  macro write data.
- i_sram_q  in  width  macro read data, valid the cycle after a read access.
- o_busy  out  1  write buffer non-empty.
- o_overflow  out  1  sticky: a write was dropped because the buffer was full.

Behaviour:
- Reset state (async assert, sync deassert handled outside):
  - buffer empty, fwd_hit_r=0
  - o_sram_cen=1, o_sram_gwen=1, o_sram_wen=all 1s
  - o_sram_a=0, o_sram_d=0
  - o_busy=0, o_overflow=0
  - o_rdata=i_sram_q
- Port control outputs are combinational from the current-cycle decision. Buffer state is registered.
- Port arbitration, one access per cycle, priority order:
  1. i_ren=1: read access. cen=0, gwen=1, wen=all 1s, a=i_raddr. If i_wen=1, push {i_waddr,i_wdata} into the buffer.
  2. i_ren=0, buffer non-empty: write the head entry (cen=0, gwen=0, wen=all 0s, a/d from head) and pop it. If i_wen=1, push in the same cycle; a simultaneous push and pop keeps the count.
  3. i_ren=0, buffer empty, i_wen=1: direct write of i_waddr/i_wdata. No push.
  4. Otherwise idle: cen=1, gwen=1, wen=all 1s.
- Ordering: buffered writes drain in FIFO order. A new write never bypasses older buffered writes.
- Full buffer:
  - A push while full with no pop in the same cycle drops the write and sets o_overflow.
  - o_overflow clears only on reset.
  - Full with a same-cycle pop (i_ren=0) accepts the push.
- Forwarding:
  - Applies in a read cycle.
  - Compare i_raddr against all valid buffer entries; the youngest match wins.
  - Register hit and data into fwd_hit_r/fwd_data_r.
  - Next cycle: o_rdata = fwd_hit_r ? fwd_data_r : i_sram_q.
- Same-cycle read and write to the same address returns the OLD data. The incoming write is not forwarded, matching registered two-port RAM semantics.
- Read latency is exactly 1 cycle under all buffer states. The read is never stalled.
- Pointers are log2(depth) bits plus a wrap bit. Full and empty are distinguished by the wrap bit. Count wraps modulo 2*depth.
- Reset mid-drain discards all buffered writes. No macro access is issued while i_rst_n=0.

Decomposition:
- Shared package/header holds the macro control polarities:
  - CEN_ON=0, CEN_OFF=1
  - GWEN_WR=0, GWEN_RD=1
  - WEN_ALL=0, WEN_NONE=all 1s
- One sub-module, serv_rf_wbuf:
  - depth x {aw,width} FIFO with push, pop, full, empty.
  - Parallel youngest-match address compare returning hit and data.
- The top level holds arbitration, forwarding registers and the overflow flag.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> cen=1, gwen=1, wen=0xFF, o_busy=0, o_overflow=0; o_rdata tracks i_sram_q.
- Direct write: i_wen=1, i_waddr=0x12, i_wdata=0xA5, i_ren=0, buffer empty -> same cycle cen=0, gwen=0, wen=0x00, a=0x12, d=0xA5; o_busy stays 0.
- Collision:
  - Stimulus: i_ren=1 (raddr 0x20) and i_wen=1 (0x12/0x5A) in cycle T.
  - T: read issued to 0x20; o_busy=1.
  - T+1 (idle): write 0x12/0x5A issued; o_busy=0 at T+2.
- Forwarding:
  - Stimulus: in cycle T, write 0x12/0x5A collides with a read of 0x20; in T+1, read 0x12 with no write.
  - T+2: o_rdata=0x5A regardless of i_sram_q.
  - Repeat with two buffered writes to 0x12 (0x11 then 0x22) -> 0x22.
- Same-cycle RAW: read and write both to 0x30 with 0x77, buffer empty -> next cycle o_rdata=i_sram_q (old value), not 0x77.
- Overflow and reset: 5 consecutive cycles with i_ren=1 and i_wen=1 (depth 4) -> o_overflow=1 after cycle 5 and the 5th write is never issued. Then assert i_rst_n=0 mid-drain -> buffer empty, no further writes, o_overflow=0.
